// File: rtl/sram_req_arbiter_pkg.sv
// Shared types and encodings for the two-master SRAM request arbiter.
package sram_req_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic RW_READ = 1'b0;

    localparam logic MST_IFETCH = 1'b0;
    localparam logic MST_LDST   = 1'b1;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way grant logic with a last-served pointer; round-robin or fixed
// priority (master 0) on a tie.
module sram_rr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       rr_en,
    input  logic       advance,
    output logic [1:0] gnt
);

    // 1 = master 1 was served last, so master 0 wins the next tie
    logic last_q;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (rr_en && !last_q) ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (advance && (gnt != 2'b00)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates instruction fetch (m0) and load/store (m1) onto the single
// valid/ready port of ext_sram and returns registered read data.
//
//  state   | meaning
//  IDLE    | no request in flight; arbitrate and latch the winner
//  REQ     | valid high, request held until ready
//  RESP    | granted master's ready pulses; pointer moves to the served master
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter bit RR     = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    output logic              m0_ready,
    input  logic              m0_rw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_dtw,
    output logic [DATA_W-1:0] m0_dtr,
    input  logic              m1_valid,
    output logic              m1_ready,
    input  logic              m1_rw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_dtw,
    output logic [DATA_W-1:0] m1_dtr,
    output logic              valid,
    input  logic              ready,
    output logic              rw,
    output logic [ADDR_W-1:0] addri,
    output logic [DATA_W-1:0] dtw,
    input  logic [DATA_W-1:0] dtr
);

    state_e            state_q;
    logic              gid_q;
    logic              valid_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] dtw_q;
    logic [DATA_W-1:0] m0_dtr_q;
    logic [DATA_W-1:0] m1_dtr_q;
    logic [1:0]        mrdy_q;

    logic [1:0]        arb_req;
    logic              arb_adv;
    logic [1:0]        gnt;

    // In RESP the arbiter sees only the served master so its pointer records it
    always_comb begin
        arb_req = {m1_valid, m0_valid};
        arb_adv = 1'b0;
        if (state_q == ST_RESP) begin
            arb_req = id_to_onehot(gid_q);
            arb_adv = 1'b1;
        end
    end

    sram_rr_arb u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .rr_en   (RR),
        .advance (arb_adv),
        .gnt     (gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            gid_q    <= MST_IFETCH;
            valid_q  <= 1'b0;
            rw_q     <= RW_READ;
            addr_q   <= '0;
            dtw_q    <= '0;
            m0_dtr_q <= '0;
            m1_dtr_q <= '0;
            mrdy_q   <= 2'b00;
        end else begin
            mrdy_q <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (gnt != 2'b00) begin
                        gid_q   <= gnt[1];
                        rw_q    <= gnt[1] ? m1_rw   : m0_rw;
                        addr_q  <= gnt[1] ? m1_addr : m0_addr;
                        dtw_q   <= gnt[1] ? m1_dtw  : m0_dtw;
                        valid_q <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ready) begin
                        valid_q <= 1'b0;
                        if (gid_q == MST_LDST) begin
                            m1_dtr_q <= dtr;
                        end else begin
                            m0_dtr_q <= dtr;
                        end
                        mrdy_q  <= id_to_onehot(gid_q);
                        state_q <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign valid    = valid_q;
    assign rw       = rw_q;
    assign addri    = addr_q;
    assign dtw      = dtw_q;
    assign m0_ready = mrdy_q[0];
    assign m1_ready = mrdy_q[1];
    assign m0_dtr   = m0_dtr_q;
    assign m1_dtr   = m1_dtr_q;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: instance 0 round-robin, instance 1 fixed
// priority, each behind a fixed-latency SRAM model.
module tb_sram_req_arbiter;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [1:0]  m0_valid, m0_ready, m0_rw, m1_valid, m1_ready, m1_rw;
    logic [1:0]  valid, ready, rw;
    logic [31:0] m0_addr [2];
    logic [31:0] m0_dtw  [2];
    logic [31:0] m0_dtr  [2];
    logic [31:0] m1_addr [2];
    logic [31:0] m1_dtw  [2];
    logic [31:0] m1_dtr  [2];
    logic [31:0] addri   [2];
    logic [31:0] dtw     [2];
    logic [31:0] dtr     [2];

    logic [1:0]  rdy_q, rdy_force, zero_lat, dtr_ovr_en;
    logic [31:0] dtr_ovr [2];
    logic [3:0]  cnt     [2];

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        int          who;
        logic [31:0] addr;
        logic        rw;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sram_req_arbiter #(
            .ADDR_W (32),
            .DATA_W (32),
            .RR     ((g == 0) ? 1'b1 : 1'b0)
        ) u_dut (
            .clk      (clk),
            .reset    (reset),
            .m0_valid (m0_valid[g]),
            .m0_ready (m0_ready[g]),
            .m0_rw    (m0_rw[g]),
            .m0_addr  (m0_addr[g]),
            .m0_dtw   (m0_dtw[g]),
            .m0_dtr   (m0_dtr[g]),
            .m1_valid (m1_valid[g]),
            .m1_ready (m1_ready[g]),
            .m1_rw    (m1_rw[g]),
            .m1_addr  (m1_addr[g]),
            .m1_dtw   (m1_dtw[g]),
            .m1_dtr   (m1_dtr[g]),
            .valid    (valid[g]),
            .ready    (ready[g]),
            .rw       (rw[g]),
            .addri    (addri[g]),
            .dtw      (dtw[g]),
            .dtr      (dtr[g])
        );
    end

    // SRAM model: ready pulses in the LAT-th cycle of valid being high
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (reset || !valid[i] || rdy_q[i]) begin
                rdy_q[i] <= 1'b0;
                cnt[i]   <= 4'd0;
            end else if (cnt[i] == 4'(LAT - 1)) begin
                rdy_q[i] <= 1'b1;
            end else begin
                cnt[i] <= cnt[i] + 4'd1;
            end
        end
    end

    assign ready = rdy_force | (zero_lat & valid) | (~zero_lat & rdy_q);

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            dtr[i] = dtr_ovr_en[i] ? dtr_ovr[i] : fdata(addri[i]);
        end
    end

    task automatic wait_resp(input int inst, input int max_cyc, output int who,
                             output logic [31:0] rdata, output logic [31:0] acc_addr,
                             output logic acc_rw, output logic [31:0] acc_dtw,
                             output bit stable, output int lat, output bit timeout);
        bit          in_req = 1'b0;
        int          acc_c = -1;
        logic [31:0] a0 = '0;
        logic [31:0] d0 = '0;
        logic        r0 = 1'b0;
        who = -1; rdata = '0; acc_addr = '0; acc_rw = 1'b0; acc_dtw = '0;
        stable = 1'b1; lat = -1; timeout = 1'b1;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (valid[inst]) begin
                if (!in_req) begin
                    a0 = addri[inst]; r0 = rw[inst]; d0 = dtw[inst]; in_req = 1'b1;
                end else if (addri[inst] !== a0 || rw[inst] !== r0 || dtw[inst] !== d0) begin
                    stable = 1'b0;
                end
                if (ready[inst]) begin
                    acc_addr = addri[inst]; acc_rw = rw[inst]; acc_dtw = dtw[inst]; acc_c = c;
                end
            end else begin
                in_req = 1'b0;
            end
            if (m0_ready[inst] || m1_ready[inst]) begin
                who = (m0_ready[inst] && m1_ready[inst]) ? 2 : (m1_ready[inst] ? 1 : 0);
                rdata = m1_ready[inst] ? m1_dtr[inst] : m0_dtr[inst];
                lat = (acc_c >= 0) ? (c - acc_c) : -1;
                timeout = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int who, lat; logic [31:0] rd, aa, ad; logic ar; bit st, to; exp_t e;
        reset = 1'b1;
        m0_addr[0] = 32'h10; m0_rw[0] = 1'b0; m0_valid[0] = 1'b1;
        m1_addr[0] = 32'h20; m1_rw[0] = 1'b0; m1_valid[0] = 1'b1;
        sb.push_back('{who: 0, addr: 32'h10, rw: 1'b0, rdata: fdata(32'h10)});
        sb.push_back('{who: 1, addr: 32'h20, rw: 1'b0, rdata: fdata(32'h20)});
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total_cnt++;
            if ({valid[0], m0_ready[0], m1_ready[0]} !== 3'b000)
                $display("FAIL reset_ctl cyc%0d: got %b expected 000", c, {valid[0], m0_ready[0], m1_ready[0]});
            else pass_cnt++;
        end
        total_cnt++;
        if (addri[0] !== 32'h0 || dtw[0] !== 32'h0 || rw[0] !== 1'b0 || m0_dtr[0] !== 32'h0 || m1_dtr[0] !== 32'h0)
            $display("FAIL reset_data: addri=%h dtw=%h rw=%b m0_dtr=%h m1_dtr=%h expected all 0",
                     addri[0], dtw[0], rw[0], m0_dtr[0], m1_dtr[0]);
        else pass_cnt++;
        reset = 1'b0;
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who) $display("FAIL reset_first_grant: got master %0d (timeout %0d) expected %0d", who, to, e.who);
        else pass_cnt++;
        total_cnt++;
        if (aa !== e.addr || rd !== e.rdata) $display("FAIL reset_first_xfer: addr %h data %h expected %h %h", aa, rd, e.addr, e.rdata);
        else pass_cnt++;
        m0_valid[0] = 1'b0;
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who || rd !== e.rdata) $display("FAIL reset_second_xfer: master %0d data %h expected %0d %h", who, rd, e.who, e.rdata);
        else pass_cnt++;
        m1_valid[0] = 1'b0;
    endtask

    task automatic test_single_read();
        int who, lat; logic [31:0] rd, aa, ad; logic ar; bit st, to; exp_t e;
        repeat (2) @(negedge clk);
        dtr_ovr_en[0] = 1'b1; dtr_ovr[0] = 32'hABCD_ABCD;
        m0_addr[0] = 32'hAAAA_AAA0; m0_rw[0] = 1'b0; m0_valid[0] = 1'b1;
        sb.push_back('{who: 0, addr: 32'hAAAA_AAA0, rw: 1'b0, rdata: 32'hABCD_ABCD});
        @(negedge clk);
        total_cnt++;
        if (valid[0] !== 1'b1 || addri[0] !== 32'hAAAA_AAA0 || rw[0] !== 1'b0)
            $display("FAIL read_issue: valid=%b addri=%h rw=%b expected 1 AAAAAAA0 0", valid[0], addri[0], rw[0]);
        else pass_cnt++;
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who) $display("FAIL read_who: got master %0d (timeout %0d) expected %0d", who, to, e.who);
        else pass_cnt++;
        total_cnt++;
        if (rd !== e.rdata) $display("FAIL read_data: got %h expected %h", rd, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1) $display("FAIL read_latency: got %0d cycles expected 1", lat);
        else pass_cnt++;
        total_cnt++;
        if (aa !== e.addr || ar !== e.rw || !st) $display("FAIL read_port: addr %h rw %b stable %0d expected %h %b 1", aa, ar, st, e.addr, e.rw);
        else pass_cnt++;
        m0_valid[0] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (m0_ready[0] !== 1'b0 || m1_ready[0] !== 1'b0) $display("FAIL read_pulse_width: m0_ready %b m1_ready %b expected 0 0", m0_ready[0], m1_ready[0]);
        else pass_cnt++;
        dtr_ovr_en[0] = 1'b0;
    endtask

    task automatic test_round_robin();
        int who, lat, n0, n1; logic [31:0] rd, aa, ad; logic ar; bit st, to; exp_t e;
        n0 = 0; n1 = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m0_addr[0] = 32'h1000; m0_rw[0] = 1'b0; m0_valid[0] = 1'b1;
        m1_addr[0] = 32'h2000; m1_rw[0] = 1'b0; m1_valid[0] = 1'b1;
        sb.push_back('{who: 0, addr: 32'h1000, rw: 1'b0, rdata: fdata(32'h1000)});
        sb.push_back('{who: 1, addr: 32'h2000, rw: 1'b0, rdata: fdata(32'h2000)});
        sb.push_back('{who: 0, addr: 32'h1004, rw: 1'b0, rdata: fdata(32'h1004)});
        sb.push_back('{who: 1, addr: 32'h2004, rw: 1'b0, rdata: fdata(32'h2004)});
        for (int k = 0; k < 4; k++) begin
            wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
            e = sb.pop_front();
            total_cnt++;
            if (to || who !== e.who || rd !== e.rdata)
                $display("FAIL rr_seq%0d: master %0d data %h expected %0d %h", k, who, rd, e.who, e.rdata);
            else pass_cnt++;
            if (who == 0) begin
                n0++;
                if (n0 >= 2) m0_valid[0] = 1'b0; else m0_addr[0] = 32'h1000 + 32'(4 * n0);
            end else if (who == 1) begin
                n1++;
                if (n1 >= 2) m1_valid[0] = 1'b0; else m1_addr[0] = 32'h2000 + 32'(4 * n1);
            end
        end
        m0_valid[0] = 1'b0; m1_valid[0] = 1'b0;
        total_cnt++;
        if (n0 !== 2 || n1 !== 2) $display("FAIL rr_counts: m0 %0d m1 %0d pulses expected 2 2", n0, n1);
        else pass_cnt++;
    endtask

    task automatic test_fixed_priority();
        int who, lat, n0, n1; logic [31:0] rd, aa, ad; logic ar; bit st, to; exp_t e;
        n0 = 0; n1 = 0;
        @(negedge clk);
        m0_addr[1] = 32'h1000; m0_rw[1] = 1'b0; m0_valid[1] = 1'b1;
        m1_addr[1] = 32'h2000; m1_rw[1] = 1'b0; m1_valid[1] = 1'b1;
        sb.push_back('{who: 0, addr: 32'h1000, rw: 1'b0, rdata: fdata(32'h1000)});
        sb.push_back('{who: 0, addr: 32'h1004, rw: 1'b0, rdata: fdata(32'h1004)});
        sb.push_back('{who: 1, addr: 32'h2000, rw: 1'b0, rdata: fdata(32'h2000)});
        sb.push_back('{who: 1, addr: 32'h2004, rw: 1'b0, rdata: fdata(32'h2004)});
        for (int k = 0; k < 4; k++) begin
            wait_resp(1, 40, who, rd, aa, ar, ad, st, lat, to);
            e = sb.pop_front();
            total_cnt++;
            if (to || who !== e.who || aa !== e.addr)
                $display("FAIL fp_seq%0d: master %0d addr %h expected %0d %h", k, who, aa, e.who, e.addr);
            else pass_cnt++;
            if (who == 0) begin
                n0++;
                if (n0 >= 2) m0_valid[1] = 1'b0; else m0_addr[1] = 32'h1000 + 32'(4 * n0);
            end else if (who == 1) begin
                n1++;
                if (n1 >= 2) m1_valid[1] = 1'b0; else m1_addr[1] = 32'h2000 + 32'(4 * n1);
            end
        end
        m0_valid[1] = 1'b0; m1_valid[1] = 1'b0;
    endtask

    task automatic test_write_hold();
        int who, lat; logic [31:0] rd, aa, ad; logic ar; bit st, to; exp_t e;
        repeat (2) @(negedge clk);
        m1_addr[0] = 32'h0000_0100; m1_rw[0] = 1'b1; m1_dtw[0] = 32'hABCD_1234; m1_valid[0] = 1'b1;
        sb.push_back('{who: 1, addr: 32'h0000_0100, rw: 1'b1, rdata: fdata(32'h0000_0100)});
        @(negedge clk);
        m1_dtw[0] = 32'hDEAD_BEEF;
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who) $display("FAIL write_who: got master %0d (timeout %0d) expected %0d", who, to, e.who);
        else pass_cnt++;
        total_cnt++;
        if (ad !== 32'hABCD_1234 || !st) $display("FAIL write_dtw_hold: dtw %h stable %0d expected ABCD1234 1", ad, st);
        else pass_cnt++;
        total_cnt++;
        if (ar !== e.rw || aa !== e.addr) $display("FAIL write_port: rw %b addr %h expected %b %h", ar, aa, e.rw, e.addr);
        else pass_cnt++;
        total_cnt++;
        if (rd !== e.rdata) $display("FAIL write_dtr: got %h expected %h", rd, e.rdata);
        else pass_cnt++;
        m1_valid[0] = 1'b0; m1_rw[0] = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        int who, lat; logic [31:0] rd, aa, ad; logic ar; bit st, to, saw; exp_t e;
        repeat (2) @(negedge clk);
        m0_addr[0] = 32'h300; m0_rw[0] = 1'b0; m0_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (valid[0] !== 1'b1) $display("FAIL midreset_in_req: valid %b expected 1", valid[0]);
        else pass_cnt++;
        reset = 1'b1; m0_valid[0] = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (valid[0] !== 1'b0) $display("FAIL midreset_valid_drop: valid %b expected 0", valid[0]);
        else pass_cnt++;
        reset = 1'b0;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (m0_ready[0] || m1_ready[0] || valid[0]) saw = 1'b1;
        end
        total_cnt++;
        if (saw !== 1'b0) $display("FAIL midreset_no_ready: activity seen %0d expected 0", saw);
        else pass_cnt++;
        m0_addr[0] = 32'h304; m0_valid[0] = 1'b1;
        sb.push_back('{who: 0, addr: 32'h304, rw: 1'b0, rdata: fdata(32'h304)});
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who || rd !== e.rdata || aa !== e.addr)
            $display("FAIL midreset_recover: master %0d addr %h data %h expected %0d %h %h", who, aa, rd, e.who, e.addr, e.rdata);
        else pass_cnt++;
        m0_valid[0] = 1'b0;
    endtask

    task automatic test_boundary();
        int who, lat; logic [31:0] rd, aa, ad; logic ar; bit st, to, saw; exp_t e;
        repeat (2) @(negedge clk);
        rdy_force[0] = 1'b1;
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (m0_ready[0] || m1_ready[0] || valid[0]) saw = 1'b1;
        end
        rdy_force[0] = 1'b0;
        total_cnt++;
        if (saw !== 1'b0) $display("FAIL idle_ready_ignored: activity seen %0d expected 0", saw);
        else pass_cnt++;

        zero_lat[0] = 1'b1;
        m1_addr[0] = 32'h400; m1_rw[0] = 1'b0; m1_valid[0] = 1'b1;
        sb.push_back('{who: 1, addr: 32'h400, rw: 1'b0, rdata: fdata(32'h400)});
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who || rd !== e.rdata) $display("FAIL zero_lat_xfer: master %0d data %h expected %0d %h", who, rd, e.who, e.rdata);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 1 || aa !== e.addr) $display("FAIL zero_lat_timing: latency %0d addr %h expected 1 %h", lat, aa, e.addr);
        else pass_cnt++;
        m1_valid[0] = 1'b0; zero_lat[0] = 1'b0;

        repeat (2) @(negedge clk);
        m0_addr[0] = 32'h500; m0_rw[0] = 1'b0; m0_valid[0] = 1'b1;
        sb.push_back('{who: 0, addr: 32'h500, rw: 1'b0, rdata: fdata(32'h500)});
        @(negedge clk);
        m0_valid[0] = 1'b0;
        wait_resp(0, 40, who, rd, aa, ar, ad, st, lat, to);
        e = sb.pop_front();
        total_cnt++;
        if (to || who !== e.who || rd !== e.rdata) $display("FAIL early_drop_resp: master %0d data %h expected %0d %h", who, rd, e.who, e.rdata);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1;
        m0_valid = '0; m1_valid = '0; m0_rw = '0; m1_rw = '0;
        rdy_force = '0; zero_lat = '0; dtr_ovr_en = '0;
        for (int i = 0; i < 2; i++) begin
            m0_addr[i] = '0; m0_dtw[i] = '0; m1_addr[i] = '0; m1_dtw[i] = '0; dtr_ovr[i] = '0;
        end
        test_reset();
        test_single_read();
        test_round_robin();
        test_fixed_priority();
        test_write_hold();
        test_reset_mid_req();
        test_boundary();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1);
    end

endmodule
